// File: rtl/pdf_key_candidate_gen_pkg.sv
// -----------------------------------------------------------------------------
// pdf_key_candidate_gen_pkg
// Shared definitions for the PDF key-search pipeline.
//   key_search_state_t : candidate generator state encoding
//   KEY_W_DEF          : default candidate key width
//   CNT_W_DEF          : default range length / sequence index width
//   PDF_HDR            : "%PDF-1." header bytes, used by the header checker
// -----------------------------------------------------------------------------
package pdf_key_candidate_gen_pkg;

    localparam int KEY_W_DEF = 128;
    localparam int CNT_W_DEF = 32;

    // Plaintext prefix every valid PDF starts with: "%PDF-1."
    localparam int          PDF_HDR_LEN = 7;
    localparam logic [55:0] PDF_HDR     = 56'h25_50_44_46_2D_31_2E;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2,
        STOPPED   = 2'd3
    } key_search_state_t;

endpackage : pdf_key_candidate_gen_pkg

// File: rtl/pdf_key_candidate_gen.sv
// -----------------------------------------------------------------------------
// pdf_key_candidate_gen
// Walks a contiguous range of candidate keys and offers them, one per
// valid/ready handshake, to the decrypt core. Each key carries its sequence
// index so a hit reported downstream can be traced back to its key.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   ena        : global clock enable; 0 freezes all state, no handshakes
//   start      : pulse; loads start_key/num_keys and begins the search
//   start_key  : first candidate key (sampled on start)
//   num_keys   : number of candidates to issue (sampled on start)
//   stop       : checker hit; halts generation
//   key_out    : current candidate key
//   key_index  : sequence index of key_out (0 = start_key)
//   key_valid  : candidate available (combinational from ena)
//   key_ready  : downstream accepts candidate
//   busy       : high while searching
//   exhausted  : sticky, range completed without stop
//   stopped    : sticky, halted by stop
//   issued_cnt : accepted candidates since last start
// -----------------------------------------------------------------------------
module pdf_key_candidate_gen
    import pdf_key_candidate_gen_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [KEY_W-1:0] start_key,
    input  logic [CNT_W-1:0] num_keys,
    input  logic             stop,
    output logic [KEY_W-1:0] key_out,
    output logic [CNT_W-1:0] key_index,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             exhausted,
    output logic             stopped,
    output logic [CNT_W-1:0] issued_cnt
);

    key_search_state_t state, next_state;

    logic [KEY_W-1:0] key_reg;
    logic [CNT_W-1:0] index_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] remaining;

    logic xfer;
    logic load;

    // Gating valid with ena guarantees no handshake can complete while frozen.
    assign key_valid  = (state == RUN) && ena;
    assign xfer       = key_valid && key_ready;
    // start is honoured in every state except RUN.
    assign load       = ena && start && (state != RUN);

    assign key_out    = key_reg;
    assign key_index  = index_reg;
    assign issued_cnt = issued_reg;
    assign busy       = (state == RUN);
    // The terminal states are themselves sticky until the next start.
    assign exhausted  = (state == EXHAUSTED);
    assign stopped    = (state == STOPPED);

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (ena) begin
                    // stop outranks exhaustion when both land in one cycle.
                    if (stop) begin
                        next_state = STOPPED;
                    end else if (xfer && (remaining == CNT_W'(1))) begin
                        next_state = EXHAUSTED;
                    end
                end
            end
            default: begin // IDLE, EXHAUSTED, STOPPED
                if (load) begin
                    next_state = (num_keys == '0) ? EXHAUSTED : RUN;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_reg    <= '0;
            index_reg  <= '0;
            issued_reg <= '0;
            remaining  <= '0;
        end else if (ena) begin
            state <= next_state;
            if (load) begin
                key_reg    <= start_key;
                index_reg  <= '0;
                issued_reg <= '0;
                remaining  <= num_keys;
            end else if (xfer) begin
                issued_reg <= issued_reg + CNT_W'(1);
                remaining  <= remaining - CNT_W'(1);
                // The final accepted key stays on key_out/key_index so the
                // terminal state reports the last key actually issued.
                if (next_state == RUN) begin
                    key_reg   <= key_reg + KEY_W'(1);
                    index_reg <= index_reg + CNT_W'(1);
                end
            end
        end
    end

endmodule : pdf_key_candidate_gen

// File: tb/tb_pdf_key_candidate_gen.sv
// -----------------------------------------------------------------------------
// tb_pdf_key_candidate_gen
// Directed bench with a scoreboard of expected (key, index) transfers.
// -----------------------------------------------------------------------------
module tb_pdf_key_candidate_gen;

    localparam int KEY_W = 128;
    localparam int CNT_W = 32;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [CNT_W-1:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b1;
    logic             start = 1'b0;
    logic [KEY_W-1:0] start_key = '0;
    logic [CNT_W-1:0] num_keys = '0;
    logic             stop = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic [CNT_W-1:0] key_index;
    logic             key_valid;
    logic             key_ready = 1'b0;
    logic             busy;
    logic             exhausted;
    logic             stopped;
    logic [CNT_W-1:0] issued_cnt;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    pdf_key_candidate_gen #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .start_key  (start_key),
        .num_keys   (num_keys),
        .stop       (stop),
        .key_out    (key_out),
        .key_index  (key_index),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .exhausted  (exhausted),
        .stopped    (stopped),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KEY_W-1:0] observed,
                         input logic [KEY_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_range(input logic [KEY_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.key = first + KEY_W'(i);
            e.idx = CNT_W'(i);
            sb_q.push_back(e);
        end
    endtask

    // One clock: at the falling edge any handshake about to complete is
    // scored, then inputs may change 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (key_valid && key_ready) begin
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_xfer: observed key %0h index %0d expected no transfer",
                       key_out, key_index);
            end
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("xfer_key", key_out, e.key);
                check("xfer_index", KEY_W'(key_index), KEY_W'(e.idx));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] n);
        start_key = k;
        num_keys  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", KEY_W'(sb_q.size()), '0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_out"},   key_out, '0);
        check({tag, "_key_index"}, KEY_W'(key_index), '0);
        check({tag, "_issued"},    KEY_W'(issued_cnt), '0);
        check({tag, "_valid"},     KEY_W'(key_valid), '0);
        check({tag, "_busy"},      KEY_W'(busy), '0);
        check({tag, "_exhausted"}, KEY_W'(exhausted), '0);
        check({tag, "_stopped"},   KEY_W'(stopped), '0);
    endtask

    initial begin
        logic [KEY_W-1:0] all_ones;
        all_ones = '1;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        // Basic range of 4 with carry into bit 8
        key_ready = 1'b1;
        push_range(KEY_W'(128'hFE), 4);
        do_start(KEY_W'(128'hFE), 4);
        check("run_busy", KEY_W'(busy), 1);
        drain(10);
        check("basic_exhausted", KEY_W'(exhausted), 1);
        check("basic_issued", KEY_W'(issued_cnt), 4);
        check("basic_valid_off", KEY_W'(key_valid), 0);
        check("basic_last_key", key_out, KEY_W'(128'h101));
        check("basic_last_index", KEY_W'(key_index), 3);

        // Backpressure held at index 1 for 3 cycles
        push_range(KEY_W'(128'h1000), 4);
        do_start(KEY_W'(128'h1000), 4);
        check("restart_exh_flag", KEY_W'(exhausted), 0);
        tick();
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_index", KEY_W'(key_index), 1);
            check("bp_key", key_out, KEY_W'(128'h1001));
        end
        check("bp_valid", KEY_W'(key_valid), 1);
        key_ready = 1'b1;
        drain(10);
        check("bp_exhausted", KEY_W'(exhausted), 1);

        // stop together with the transfer of index 2
        push_range(KEY_W'(128'h500), 3);
        do_start(KEY_W'(128'h500), 10);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_pending", KEY_W'(sb_q.size()), 0);
        check("stop_issued", KEY_W'(issued_cnt), 3);
        check("stop_stopped", KEY_W'(stopped), 1);
        check("stop_exhausted", KEY_W'(exhausted), 0);
        check("stop_index", KEY_W'(key_index), 2);
        check("stop_key", key_out, KEY_W'(128'h502));
        check("stop_busy", KEY_W'(busy), 0);

        // Restart from STOPPED with wrap from all-ones
        push_range(all_ones, 2);
        do_start(all_ones, 2);
        check("wrap_stopped_clr", KEY_W'(stopped), 0);
        check("wrap_index0", KEY_W'(key_index), 0);
        check("wrap_issued0", KEY_W'(issued_cnt), 0);
        drain(10);
        check("wrap_exhausted", KEY_W'(exhausted), 1);
        check("wrap_last_key", key_out, '0);
        check("wrap_issued", KEY_W'(issued_cnt), 2);

        // Empty range: exhausted immediately, never valid
        do_start(KEY_W'(128'h77), 0);
        check("empty_exhausted", KEY_W'(exhausted), 1);
        check("empty_issued", KEY_W'(issued_cnt), 0);
        check("empty_key", key_out, KEY_W'(128'h77));
        tick();
        tick();
        check("empty_valid", KEY_W'(key_valid), 0);

        // ena low for 5 cycles mid-RUN, start pulse inside the window
        push_range(KEY_W'(128'h2000), 8);
        do_start(KEY_W'(128'h2000), 8);
        tick();
        tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start_key = KEY_W'(128'h9999);
                num_keys  = 3;
                start     = 1'b1;
            end
            tick();
            start = 1'b0;
            check("frz_issued", KEY_W'(issued_cnt), 2);
            check("frz_index", KEY_W'(key_index), 2);
            check("frz_valid", KEY_W'(key_valid), 0);
        end
        check("frz_busy", KEY_W'(busy), 1);
        ena = 1'b1;
        drain(20);
        check("frz_exhausted", KEY_W'(exhausted), 1);
        check("frz_issued_end", KEY_W'(issued_cnt), 8);

        // rst mid-RUN at index 5
        push_range(KEY_W'(128'h3000), 5);
        do_start(KEY_W'(128'h3000), 10);
        drain(10);
        key_ready = 1'b0;
        check("pre_rst_index", KEY_W'(key_index), 5);
        ena = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ena = 1'b1;
        check_reset_values("midrun_rst");

        // rst wins over start
        rst       = 1'b1;
        start_key = KEY_W'(128'h4444);
        num_keys  = 5;
        start     = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_over_start_busy", KEY_W'(busy), 0);
        check("rst_over_start_key", key_out, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pdf_key_candidate_gen
